// File: rtl/commit_trace_capture_pkg.sv
// Shared record layout for the commit trace capture block: field widths, header struct,
// and bit offsets of each field above the cycle stamp.
package commit_trace_capture_pkg;

    localparam int DATA_W      = 16;
    localparam int REG_W       = 3;
    localparam int CYCLE_W_DEF = 16;

    typedef struct packed {
        logic              halt;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] maddr;
        logic [DATA_W-1:0] mdata;
    } rec_hdr_t;

    localparam int REC_HDR_W = $bits(rec_hdr_t);

    // Field LSB positions inside the header; the header sits directly above the cycle stamp.
    localparam int REC_MDATA = 0;
    localparam int REC_MADDR = REC_MDATA + DATA_W;
    localparam int REC_WDATA = REC_MADDR + DATA_W;
    localparam int REC_WREG  = REC_WDATA + DATA_W;
    localparam int REC_MEMWR = REC_WREG + REG_W;
    localparam int REC_MEMRD = REC_MEMWR + 1;
    localparam int REC_REGWR = REC_MEMRD + 1;
    localparam int REC_HALT  = REC_REGWR + 1;

endpackage

// File: rtl/commit_trace_capture_if.sv
// Commit observation inputs, record drain port and status outputs of commit_trace_capture.
// Cache statistic counters exist only when CACHE_STATS_EN is defined.
interface commit_trace_capture_if
    import commit_trace_capture_pkg::*;
#(
    parameter int CW = CYCLE_W_DEF
);
    logic                  cap_en;
    logic                  RegWrite;
    logic [REG_W-1:0]      WriteRegister;
    logic [DATA_W-1:0]     WriteData;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DATA_W-1:0]     MemAddress;
    logic [DATA_W-1:0]     MemDataIn;
    logic [DATA_W-1:0]     MemDataOut;
    logic                  Halt;
    logic                  ICacheReq;
    logic                  ICacheHit;
    logic                  DCacheReq;
    logic                  DCacheHit;

    logic                  out_valid;
    logic                  out_ready;
    logic [REC_HDR_W+CW-1:0] out_rec;
    logic                  overflow;
    logic                  halted;
    logic                  done;
    logic [31:0]           cycle_count;
    logic [31:0]           inst_count;
`ifdef CACHE_STATS_EN
    logic [31:0]           icache_req_cnt;
    logic [31:0]           icache_hit_cnt;
    logic [31:0]           dcache_req_cnt;
    logic [31:0]           dcache_hit_cnt;
`endif

    modport master (
        output cap_en, RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemDataIn, MemDataOut, Halt,
               ICacheReq, ICacheHit, DCacheReq, DCacheHit, out_ready,
`ifdef CACHE_STATS_EN
        input  icache_req_cnt, icache_hit_cnt, dcache_req_cnt, dcache_hit_cnt,
`endif
        input  out_valid, out_rec, overflow, halted, done, cycle_count, inst_count
    );

    modport slave (
        input  cap_en, RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemDataIn, MemDataOut, Halt,
               ICacheReq, ICacheHit, DCacheReq, DCacheHit, out_ready,
`ifdef CACHE_STATS_EN
        output icache_req_cnt, icache_hit_cnt, dcache_req_cnt, dcache_hit_cnt,
`endif
        output out_valid, out_rec, overflow, halted, done, cycle_count, inst_count
    );

endinterface

// File: rtl/commit_trace_capture_trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head output that shows a record
// one edge after it is pushed into an empty FIFO.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, rd_q, rd_n;
    logic             do_push, do_pop;

    // NOTE: always_comb uses blocking '=' and assigns every output on every path, so no latch forms.
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        rd_n    = rd_q + (AW+1)'(do_pop);
    end

    assign valid = ~empty;

    // NOTE: the storage array is deliberately left out of reset; only pointers define its contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            dout <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            rd_q <= rd_n;
            // Next head is the entry being written this edge: bypass the array.
            if (do_push && (rd_n == wr_q)) dout <= din;
            else                           dout <= mem[rd_n[AW-1:0]];
        end
    end

endmodule

// File: rtl/commit_trace_capture.sv
// Commit trace capture top: packs per-cycle commit activity into records, queues them in
// trace_fifo, counts cycles/instructions and freezes after halt. CACHE_STATS_EN adds cache counters.
module commit_trace_capture
    import commit_trace_capture_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = CYCLE_W_DEF
) (
    input logic                  clk,
    input logic                  rst,
    commit_trace_capture_if.slave bus
);
    localparam int RW = REC_HDR_W + CW;

    logic          run, capture, mem_acc, full, empty;
    rec_hdr_t      hdr;
    logic [RW-1:0] rec;
    logic          halted_q, done_q, overflow_q;
    logic [31:0]   cycle_q, inst_q;

    always_comb begin
        run     = bus.cap_en & ~halted_q;
        capture = run & (bus.RegWrite | bus.MemRead | bus.MemWrite | bus.Halt);
        mem_acc = bus.MemRead | bus.MemWrite;
        hdr       = '0;
        hdr.halt  = bus.Halt;
        hdr.regwr = bus.RegWrite;
        hdr.memrd = bus.MemRead;
        hdr.memwr = bus.MemWrite;
        hdr.wreg  = bus.RegWrite ? bus.WriteRegister : '0;
        hdr.wdata = bus.RegWrite ? bus.WriteData : '0;
        hdr.maddr = mem_acc ? bus.MemAddress : '0;
        hdr.mdata = bus.MemWrite ? bus.MemDataIn : (bus.MemRead ? bus.MemDataOut : '0);
        rec       = {hdr, cycle_q[CW-1:0]};
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .din   (rec),
        .pop   (bus.out_ready),
        .dout  (bus.out_rec),
        .valid (bus.out_valid),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            inst_q     <= '0;
        end else begin
            if (run) cycle_q <= cycle_q + 32'd1;
            if (capture & (bus.Halt | bus.RegWrite | bus.MemWrite)) inst_q <= inst_q + 32'd1;
            if (capture & bus.Halt) halted_q <= 1'b1;
            // A full FIFO can still accept a push when the head leaves on the same edge.
            if (capture & full & ~bus.out_ready) overflow_q <= 1'b1;
            done_q <= halted_q & empty;
        end
    end

    assign bus.halted      = halted_q;
    assign bus.done        = done_q;
    assign bus.overflow    = overflow_q;
    assign bus.cycle_count = cycle_q;
    assign bus.inst_count  = inst_q;

`ifdef CACHE_STATS_EN
    logic [31:0] icr_q, ich_q, dcr_q, dch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icr_q <= '0;
            ich_q <= '0;
            dcr_q <= '0;
            dch_q <= '0;
        end else if (run) begin
            icr_q <= icr_q + 32'(bus.ICacheReq);
            ich_q <= ich_q + 32'(bus.ICacheHit);
            dcr_q <= dcr_q + 32'(bus.DCacheReq);
            dch_q <= dch_q + 32'(bus.DCacheHit);
        end
    end

    assign bus.icache_req_cnt = icr_q;
    assign bus.icache_hit_cnt = ich_q;
    assign bus.dcache_req_cnt = dcr_q;
    assign bus.dcache_hit_cnt = dch_q;
`else
    logic unused_cache;
    assign unused_cache = ^{bus.ICacheReq, bus.ICacheHit, bus.DCacheReq, bus.DCacheHit};
`endif

endmodule
